// File: rtl/vpu_req_dispatcher_pkg.sv
// Shared types for the VPU request dispatcher: command struct, op types,
// SRAM read-port geometry and the dispatcher state encoding.
package vpu_req_dispatcher_pkg;

    localparam int SRAM_R_PORT_CNT = 2;   // SRAM read ports feeding the VPU
    localparam int SRC_OPERAND_CNT = 2;   // most source operands any op can use
    localparam int VPU_ADDR_W      = 16;  // address width carried in vpu_cmd_t

    typedef enum logic [1:0] {
        OP_EXEC  = 2'd0,   // two-operand execute, always reads both ports
        OP_UNARY = 2'd1,   // one source operand
        OP_LOAD  = 2'd2,   // one source operand
        OP_NOP   = 2'd3    // no source operands
    } op_type_t;

    typedef struct packed {
        op_type_t    op_type;
        logic [3:0]  func;
    } op_func_t;

    typedef struct packed {
        op_func_t                                     op_func;
        logic [SRAM_R_PORT_CNT-1:0]                   rvalid;
        logic [SRAM_R_PORT_CNT-1:0][VPU_ADDR_W-1:0]   raddr;
        logic [VPU_ADDR_W-1:0]                        waddr;
    } vpu_cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } disp_state_t;

    // Number of source operands each op type reads
    function automatic int src_operand_cnt(input op_type_t t);
        case (t)
            OP_EXEC:  return SRC_OPERAND_CNT;
            OP_UNARY: return 1;
            OP_LOAD:  return 1;
            default:  return 0;
        endcase
    endfunction

    // EXEC reads both ports unconditionally; other ops keep the host mask
    // only on ports their operand count covers.
    function automatic logic [SRAM_R_PORT_CNT-1:0] rvalid_filter(
        input op_type_t t, input logic [SRAM_R_PORT_CNT-1:0] mask);
        logic [SRAM_R_PORT_CNT-1:0] r;
        r = '0;
        if (t == OP_EXEC) begin
            r = '1;
        end else begin
            for (int i = 0; i < SRAM_R_PORT_CNT; i++)
                if (i < src_operand_cnt(t)) r[i] = mask[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/vpu_req_dispatcher_if.sv
// REQ_IF handshake between the dispatcher (src) and the VPU controller (dst).
interface vpu_req_if #(
    parameter int ADDR_W = 16
);
    import vpu_req_dispatcher_pkg::*;

    logic                                  valid;
    logic                                  ready;
    op_func_t                              op_func;
    logic [SRAM_R_PORT_CNT-1:0]            rvalid;
    logic [SRAM_R_PORT_CNT-1:0][ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0]                     waddr;

    modport src (output valid, op_func, rvalid, raddr, waddr, input ready);
    modport dst (input valid, op_func, rvalid, raddr, waddr, output ready);

endinterface

// File: rtl/vpu_req_dispatcher_cmd_fifo.sv
// Synchronous command FIFO (DEPTH x vpu_cmd_t). Full/empty come from a
// registered occupancy count, so a push is never accepted on the strength
// of a same-cycle pop.
module vpu_cmd_fifo
    import vpu_req_dispatcher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  vpu_cmd_t wdata,
    output vpu_cmd_t rdata,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    vpu_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_req_dispatcher.sv
// VPU request dispatcher: queues host commands and issues them one at a time
// on REQ_IF, holding each request until accepted and then waiting for the
// VPU completion pulse before issuing the next.
// Optional watchdog on the completion wait: define VPU_DISPATCH_TIMEOUT_EN.
module vpu_req_dispatcher
    import vpu_req_dispatcher_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int ADDR_W         = 16,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  vpu_cmd_t         cmd_i,
    vpu_req_if.src           req_if,
    input  logic             vpu_done_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] issued_cnt_o,
    output logic [CNT_W-1:0] done_cnt_o,
    output logic             err_o
);
    disp_state_t state;
    vpu_cmd_t    head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    // Head is consumed only when the FSM loads it into the request register
    assign pop         = (state == S_IDLE) && !fifo_empty;
    assign cmd_ready_o = !fifo_full;
    assign busy_o      = !fifo_empty || (state != S_IDLE);

    vpu_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid_i),
        .pop   (pop),
        .wdata (cmd_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef VPU_DISPATCH_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog;
    logic              err_q;
    assign err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign err_o = 1'b0;
`endif

    // Issue FSM with registered REQ_IF outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            req_if.valid   <= 1'b0;
            req_if.op_func <= '0;
            req_if.rvalid  <= '0;
            req_if.raddr   <= '0;
            req_if.waddr   <= '0;
            issued_cnt_o   <= '0;
            done_cnt_o     <= '0;
`ifdef VPU_DISPATCH_TIMEOUT_EN
            wdog           <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        req_if.valid   <= 1'b1;
                        req_if.op_func <= head.op_func;
                        req_if.rvalid  <= rvalid_filter(head.op_func.op_type, head.rvalid);
                        for (int i = 0; i < SRAM_R_PORT_CNT; i++)
                            req_if.raddr[i] <= ADDR_W'(head.raddr[i]);
                        req_if.waddr   <= ADDR_W'(head.waddr);
                        state          <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Payload is left untouched here so it stays stable while valid
                    if (req_if.ready) begin
                        req_if.valid <= 1'b0;
                        issued_cnt_o <= issued_cnt_o + 1'b1;
                        state        <= S_WAIT;
`ifdef VPU_DISPATCH_TIMEOUT_EN
                        wdog         <= '0;
`endif
                    end
                end
                S_WAIT: begin
`ifdef VPU_DISPATCH_TIMEOUT_EN
                    if (vpu_done_i) begin
                        done_cnt_o <= done_cnt_o + 1'b1;
                        state      <= S_IDLE;
                    end else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        // Give up on this completion; a late pulse lands in S_IDLE and is dropped
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`else
                    if (vpu_done_i) begin
                        done_cnt_o <= done_cnt_o + 1'b1;
                        state      <= S_IDLE;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_req_dispatcher.sv
// Self-checking bench for vpu_req_dispatcher: directed scenarios plus a
// randomized producer/consumer run against a queue-based reference model.
`timescale 1ns/1ps
module tb_vpu_req_dispatcher;
    import vpu_req_dispatcher_pkg::*;

    localparam int CNT_W = 16;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             vpu_done = 1'b0;
    vpu_cmd_t         cmd = '0;
    logic             cmd_ready;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;

    vpu_req_if #(.ADDR_W(VPU_ADDR_W)) rif();

    vpu_req_dispatcher #(
        .CMD_DEPTH(4), .ADDR_W(VPU_ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_i(cmd), .req_if(rif), .vpu_done_i(vpu_done), .busy_o(busy),
        .issued_cnt_o(issued_cnt), .done_cnt_o(done_cnt), .err_o(err)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_issued = '0;
    logic [CNT_W-1:0] exp_done = '0;
    vpu_cmd_t         exp_q[$];

    // Reference rule for the issued payload: EXEC reads both ports, one-operand
    // ops keep only port 0 of the host mask, NOP reads none.
    function automatic vpu_cmd_t expect_req(input vpu_cmd_t c);
        vpu_cmd_t e;
        e = c;
        case (c.op_func.op_type)
            OP_EXEC:           e.rvalid = 2'b11;
            OP_UNARY, OP_LOAD: e.rvalid = {1'b0, c.rvalid[0]};
            default:           e.rvalid = 2'b00;
        endcase
        return e;
    endfunction

    function automatic vpu_cmd_t observed();
        vpu_cmd_t o;
        o.op_func = rif.op_func;
        o.rvalid  = rif.rvalid;
        o.raddr   = rif.raddr;
        o.waddr   = rif.waddr;
        return o;
    endfunction

    function automatic vpu_cmd_t rand_cmd(input logic [15:0] wa);
        vpu_cmd_t c;
        c.op_func.op_type = op_type_t'($urandom_range(0, 3));
        c.op_func.func    = 4'($urandom);
        c.rvalid          = 2'($urandom);
        c.raddr[0]        = 16'($urandom);
        c.raddr[1]        = 16'($urandom);
        c.waddr           = wa;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (rif.valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = rif.valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rif.valid); end
        checks++; if (observed() !== vpu_cmd_t'('0)) begin failures++; $display("FAIL reset_payload got=%h exp=0", observed()); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (issued_cnt !== '0 || done_cnt !== '0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", issued_cnt, done_cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_exec();
        vpu_cmd_t c;
        c = rand_cmd(16'h0100);
        c.op_func.op_type = OP_EXEC;
        c.rvalid = 2'b00;
        rif.ready = 1'b1;
        cmd = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rif.valid); end
        step();
        checks++; if (rif.valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rif.valid); end
        checks++; if (observed() !== expect_req(c)) begin failures++; $display("FAIL single_payload got=%h exp=%h", observed(), expect_req(c)); end
        step();
        exp_issued++;
        rif.ready = 1'b0;
        checks++; if (rif.valid !== 1'b0) begin failures++; $display("FAIL single_valid_drop got=%b exp=0", rif.valid); end
        checks++; if (issued_cnt !== exp_issued) begin failures++; $display("FAIL single_issued got=%0d exp=%0d", issued_cnt, exp_issued); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
        step();
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        exp_done++;
        checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL single_done got=%0d exp=%0d", done_cnt, exp_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_backpressure();
        vpu_cmd_t c;
        c = rand_cmd(16'h0200);
        c.op_func.op_type = OP_UNARY;
        c.rvalid = 2'b11;
        rif.ready = 1'b0;
        cmd = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd = rand_cmd(16'hdead);
        step();
        for (int k = 0; k < 5; k++) begin
            checks++; if (rif.valid !== 1'b1 || observed() !== expect_req(c)) begin failures++; $display("FAIL bp_hold cycle=%0d got=%b/%h exp=1/%h", k, rif.valid, observed(), expect_req(c)); end
            step();
        end
        rif.ready = 1'b1;
        checks++; if (observed() !== expect_req(c)) begin failures++; $display("FAIL bp_payload_at_accept got=%h exp=%h", observed(), expect_req(c)); end
        step();
        rif.ready = 1'b0;
        exp_issued++;
        checks++; if (rif.valid !== 1'b0 || issued_cnt !== exp_issued) begin failures++; $display("FAIL bp_accept got=%b/%0d exp=0/%0d", rif.valid, issued_cnt, exp_issued); end
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        exp_done++;
        checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL bp_done got=%0d exp=%0d", done_cnt, exp_done); end
    endtask

    task automatic test_done_ignored();
        vpu_cmd_t c;
        rif.ready = 1'b0;
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        checks++; if (done_cnt !== exp_done || busy !== 1'b0 || rif.valid !== 1'b0) begin failures++; $display("FAIL done_in_idle got=%0d/%b/%b exp=%0d/0/0", done_cnt, busy, rif.valid, exp_done); end
        c = rand_cmd(16'h0300);
        cmd = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL done_in_req got=%0d exp=%0d", done_cnt, exp_done); end
        checks++; if (rif.valid !== 1'b1 || observed() !== expect_req(c)) begin failures++; $display("FAIL done_in_req_hold got=%b/%h exp=1/%h", rif.valid, observed(), expect_req(c)); end
        rif.ready = 1'b1;
        step();
        rif.ready = 1'b0;
        exp_issued++;
        checks++; if (issued_cnt !== exp_issued) begin failures++; $display("FAIL done_ign_issued got=%0d exp=%0d", issued_cnt, exp_issued); end
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        exp_done++;
        checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL done_ign_wait got=%0d exp=%0d", done_cnt, exp_done); end
    endtask

    task automatic test_fill_order();
        vpu_cmd_t c;
        vpu_cmd_t c5;
        bit       ok;
        rif.ready = 1'b0;
        // One entry is popped into the request register, so five fit back to back
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd(16'(i));
            cmd = c; cmd_valid = 1'b1;
            checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL fill_ready push=%0d got=%b exp=1", i, cmd_ready); end
            step();
            exp_q.push_back(c);
        end
        c5 = rand_cmd(16'd5);
        cmd = c5;
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL fill_full got=%b/%b exp=0/1", cmd_ready, busy); end
        checks++; if (rif.valid !== 1'b1 || observed() !== expect_req(exp_q[0])) begin failures++; $display("FAIL fill_head got=%h exp=%h", observed(), expect_req(exp_q[0])); end
        rif.ready = 1'b1;
        step();
        rif.ready = 1'b0;
        void'(exp_q.pop_front());
        exp_issued++;
        checks++; if (rif.valid !== 1'b0 || issued_cnt !== exp_issued || cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_accept0 got=%b/%0d/%b exp=0/%0d/0", rif.valid, issued_cnt, cmd_ready, exp_issued); end
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        exp_done++;
        checks++; if (done_cnt !== exp_done || cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_done0 got=%0d/%b exp=%0d/0", done_cnt, cmd_ready, exp_done); end
        // Pop edge while full: the held push is refused, ready rises afterwards
        step();
        checks++; if (rif.valid !== 1'b1 || cmd_ready !== 1'b1) begin failures++; $display("FAIL fill_pop_refuse got=%b/%b exp=1/1", rif.valid, cmd_ready); end
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(c5);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL fill_refill got=%b exp=0", cmd_ready); end
        for (int n = 0; n < 5; n++) begin
            wait_valid(8, ok);
            checks++; if (!ok) begin failures++; $display("FAIL fill_wait item=%0d got=timeout exp=valid", n + 1); end
            checks++; if (exp_q.size() == 0 || observed() !== expect_req(exp_q[0])) begin failures++; $display("FAIL fill_order item=%0d got=%h exp_waddr=%0d", n + 1, observed(), n + 1); end
            rif.ready = 1'b1;
            step();
            rif.ready = 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            exp_issued++;
            checks++; if (issued_cnt !== exp_issued) begin failures++; $display("FAIL fill_issued got=%0d exp=%0d", issued_cnt, exp_issued); end
            vpu_done = 1'b1;
            step();
            vpu_done = 1'b0;
            exp_done++;
            checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL fill_done got=%0d exp=%0d", done_cnt, exp_done); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fill_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        fork
            begin : producer
                vpu_cmd_t c;
                bit       took;
                int       guard;
                for (int i = 0; i < N; i++) begin
                    c = rand_cmd(16'($urandom));
                    cmd = c; cmd_valid = 1'b1;
                    guard = 0;
                    do begin
                        took = cmd_ready;
                        step();
                        guard++;
                    end while (!took && guard < 300);
                    cmd_valid = 1'b0;
                    if (took) exp_q.push_back(c);
                    checks++; if (!took) begin failures++; $display("FAIL rand_push_stall item=%0d got=timeout exp=accept", i); end
                    repeat ($urandom_range(0, 3)) step();
                end
            end
            begin : consumer
                int got;
                int guard;
                bit hs;
                got = 0;
                guard = 0;
                while (got < N && guard < 6000) begin
                    if (rif.valid) begin
                        checks++; if (exp_q.size() == 0 || observed() !== expect_req(exp_q[0])) begin failures++; $display("FAIL rand_payload item=%0d got=%h qsize=%0d", got, observed(), exp_q.size()); end
                        hs = ($urandom_range(0, 2) != 0);
                        rif.ready = hs;
                        step();
                        guard++;
                        if (hs) begin
                            rif.ready = 1'b0;
                            if (exp_q.size() != 0) void'(exp_q.pop_front());
                            got++;
                            exp_issued++;
                            checks++; if (rif.valid !== 1'b0 || issued_cnt !== exp_issued) begin failures++; $display("FAIL rand_accept got=%b/%0d exp=0/%0d", rif.valid, issued_cnt, exp_issued); end
                            repeat ($urandom_range(0, 4)) step();
                            vpu_done = 1'b1;
                            step();
                            vpu_done = 1'b0;
                            exp_done++;
                            checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL rand_done got=%0d exp=%0d", done_cnt, exp_done); end
                        end
                    end else begin
                        rif.ready = 1'($urandom_range(0, 1));
                        step();
                        guard++;
                    end
                end
                rif.ready = 1'b0;
                checks++; if (got != N) begin failures++; $display("FAIL rand_drain got=%0d exp=%0d", got, N); end
            end
        join
        step();
        checks++; if (busy !== 1'b0 || issued_cnt !== exp_issued || done_cnt !== exp_done) begin failures++; $display("FAIL rand_final got=%b/%0d/%0d exp=0/%0d/%0d", busy, issued_cnt, done_cnt, exp_issued, exp_done); end
    endtask

    task automatic test_timeout();
        vpu_cmd_t c;
        c = rand_cmd(16'h0400);
        rif.ready = 1'b0;
        cmd = c; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        rif.ready = 1'b1;
        step();
        rif.ready = 1'b0;
        exp_issued++;
`ifdef VPU_DISPATCH_TIMEOUT_EN
        begin
            bit ok;
            repeat (TMO - 1) step();
            checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_early got=%b/%b exp=0/1", err, busy); end
            step();
            checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL tmo_fire got=%b/%b exp=1/0", err, busy); end
            vpu_done = 1'b1;
            step();
            vpu_done = 1'b0;
            checks++; if (done_cnt !== exp_done) begin failures++; $display("FAIL tmo_late_done got=%0d exp=%0d", done_cnt, exp_done); end
            c = rand_cmd(16'h0401);
            cmd = c; cmd_valid = 1'b1;
            step();
            cmd_valid = 1'b0;
            wait_valid(4, ok);
            checks++; if (!ok || observed() !== expect_req(c)) begin failures++; $display("FAIL tmo_next_issue got=%b/%h exp=1/%h", ok, observed(), expect_req(c)); end
            rif.ready = 1'b1;
            step();
            rif.ready = 1'b0;
            exp_issued++;
            vpu_done = 1'b1;
            step();
            vpu_done = 1'b0;
            exp_done++;
            checks++; if (done_cnt !== exp_done || issued_cnt !== exp_issued || err !== 1'b1) begin failures++; $display("FAIL tmo_after got=%0d/%0d/%b exp=%0d/%0d/1", done_cnt, issued_cnt, err, exp_done, exp_issued); end
        end
`else
        repeat (100) step();
        checks++; if (err !== 1'b0 || busy !== 1'b1 || rif.valid !== 1'b0) begin failures++; $display("FAIL nowdog_wait got=%b/%b/%b exp=0/1/0", err, busy, rif.valid); end
        vpu_done = 1'b1;
        step();
        vpu_done = 1'b0;
        exp_done++;
        checks++; if (done_cnt !== exp_done || busy !== 1'b0) begin failures++; $display("FAIL nowdog_done got=%0d/%b exp=%0d/0", done_cnt, busy, exp_done); end
`endif
    endtask

    task automatic test_reset_mid();
        rif.ready = 1'b0;
        cmd = rand_cmd(16'h0500); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        rif.ready = 1'b1;
        step();
        rif.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd = rand_cmd(16'(16'h0510 + i)); cmd_valid = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1 || issued_cnt === '0) begin failures++; $display("FAIL rstmid_pre got=%b/%0d exp=1/nonzero", busy, issued_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rif.valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl got=%b/%b/%b exp=0/0/1", rif.valid, busy, cmd_ready); end
        checks++; if (issued_cnt !== '0 || done_cnt !== '0 || err !== 1'b0) begin failures++; $display("FAIL rstmid_cnt got=%0d/%0d/%b exp=0/0/0", issued_cnt, done_cnt, err); end
        exp_issued = '0;
        exp_done = '0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        checks++; if (rif.valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_dropped got=%b/%b exp=0/0", rif.valid, busy); end
    endtask

    initial begin
        rif.ready = 1'b0;
        test_reset();
        test_single_exec();
        test_backpressure();
        test_done_ignored();
        test_fill_order();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL global_timeout got=stuck exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/vpu_req_dispatcher.md
Name: vpu_req_dispatcher

Overview:
Initiator (source) side of the REQ_IF handshake consumed by the VPU controller. Buffers VPU commands from the host/NPU sequencer in a small FIFO and issues them one at a time on REQ_IF. Holds each request stable until accepted, then waits for the VPU completion pulse before issuing the next. Exposes busy/status and issue/completion counts.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
ADDR_W, 16, SRAM operand/result address width
CNT_W, 16, width of issued/completed counters
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  host command valid
cmd_ready_o  out  1  FIFO not full
cmd_i  in  $bits(vpu_cmd_t)  op_func, per-port rvalid mask, src addrs, dst addr
req_if  REQ_IF.src  -  drives valid, op_func, rvalid[SRAM_R_PORT_CNT], raddr[], waddr; samples ready
vpu_done_i  in  1  one-cycle pulse from VPU at WB completion
busy_o  out  1  FIFO non-empty or request outstanding
issued_cnt_o  out  CNT_W  requests accepted by VPU
done_cnt_o  out  CNT_W  completions received
err_o  out  1  sticky watchdog error (optional feature only; else tied 0)

Behaviour:
- Reset (async assert, sync deassert by flop behaviour): FIFO emptied, state S_IDLE, req_if.valid=0, req_if payload=0, cmd_ready_o=1, busy_o=0, counters=0, err_o=0. Reset mid-operation drops outstanding request and queued commands without handshake.
- FIFO push: cmd_valid_i && cmd_ready_o; cmd_ready_o = !full (registered count, no same-cycle pop bypass). Pop on S_IDLE->S_REQ.
- Full + simultaneous pop: push refused that cycle; cmd_ready_o rises next cycle. Empty: no issue, no bypass (min latency push->req_if.valid = 2 cycles).
- FSM:
  S_IDLE: if FIFO non-empty -> pop head into request register, req_if.valid=1 next cycle, go S_REQ.
  S_REQ: valid held high, payload stable; on valid && ready -> valid=0 next cycle, issued_cnt++, go S_WAIT.
  S_WAIT: on vpu_done_i -> done_cnt++, go S_IDLE (next request valid earliest 2 cycles after done).
- vpu_done_i outside S_WAIT: ignored, not counted.
- rvalid bits not covered by op_func's operand count are forced 0 (op_type EXEC uses both ports; others as mask).
- Counters wrap modulo 2^CNT_W silently.
- busy_o = !empty || state!=S_IDLE.
- At most one request outstanding; payload never changes while valid=1.

Optional Feature:
VPU_DISPATCH_TIMEOUT_EN: defined -> watchdog counter cleared on S_WAIT entry, increments each S_WAIT cycle; reaching TIMEOUT_CYCLES sets err_o (sticky until reset) and forces S_IDLE; late vpu_done_i then ignored. Undefined -> no counter, S_WAIT waits indefinitely, err_o constant 0.

Decomposition:
- VPU_PKG: vpu_cmd_t struct, op_func_t/op_type enum (EXEC etc.), SRAM_R_PORT_CNT, SRC_OPERAND_CNT, dispatcher state enum.
- Sub-module: vpu_cmd_fifo (synchronous FIFO, CMD_DEPTH x vpu_cmd_t, full/empty, async reset).

Test Plan:
- Single EXEC cmd, ready tied 1 -> valid high 1 cycle at cycle 2 after push, issued_cnt=1; done pulse -> done_cnt=1, busy_o=0.
- ready held 0 for 5 cycles -> valid and payload stable all 5 cycles; accepted on cycle ready=1, issued_cnt=1.
- Push 5 cmds back-to-back, no done -> cmd_ready_o=0 after 4 in FIFO... after 1 popped, 4 queued; 5th waits; strict issue order by dst addr 0..4.
- vpu_done_i pulsed in S_IDLE and S_REQ -> done_cnt stays 0; no state change.
- rst_n asserted while in S_WAIT with 3 queued -> valid=0, busy_o=0, counters 0 immediately (async).
- With VPU_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> err_o=1 after 8 S_WAIT cycles, next cmd issued; without macro, still in S_WAIT after 100 cycles, err_o=0.
